// File: rtl/mem_access_stage.sv
// RV32I memory-access stage: forwards ALU results, runs LB/LH/LW/LBU/LHU/SB/SH/SW
// over a req/ack data port, and flags misaligned or undefined accesses as traps.
module mem_access_stage #(
  parameter int         XLEN      = 32,
  parameter logic [6:0] OP_LOAD   = 7'b0000011,
  parameter logic [6:0] OP_STORE  = 7'b0100011,
  parameter logic [6:0] OP_BRANCH = 7'b1100011
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_vld,
  input  logic [XLEN-1:0] i_result,
  input  logic [XLEN-1:0] i_data_store,
  input  logic [XLEN-1:0] i_pc,
  input  logic [2:0]      i_func3,
  input  logic [6:0]      i_opcode,
  input  logic [4:0]      i_rd,
  output logic            o_stall,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_be,
  input  logic            i_dmem_ack,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_vld,
  output logic            o_wr,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic [XLEN-1:0] o_pc,
  output logic [4:0]      o_fwd_rd,
  output logic [XLEN-1:0] o_fwd_data,
  output logic            o_trap,
  output logic [XLEN-1:0] o_trap_pc
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state_reg;

  logic            we_reg;
  logic [XLEN-1:0] addr_reg, wdata_reg, pc_reg;
  logic [3:0]      be_reg;
  logic [2:0]      func3_reg;
  logic [1:0]      off_reg;
  logic [4:0]      rd_reg;

  logic            is_load, is_store, f3_ok, misaligned;
  logic [1:0]      off;
  logic [3:0]      be_next;
  logic [XLEN-1:0] wdata_next, load_data;
  logic [7:0]      rbyte [4];
  logic [7:0]      lbyte;
  logic [15:0]     lhalf;

  assign is_load  = (i_opcode == OP_LOAD);
  assign is_store = (i_opcode == OP_STORE);
  assign off      = i_result[1:0];

  assign misaligned = ((i_func3[1:0] == 2'b01) && i_result[0]) ||
                      ((i_func3[1:0] == 2'b10) && (i_result[1:0] != 2'b00));

  always_comb begin
    f3_ok = 1'b0;
    case (i_func3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = is_load;
      default:                f3_ok = 1'b0;
    endcase
  end

  // Byte enables mark the accessed lane for loads too; wdata is only driven for stores.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = '0;
    case (i_func3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << off;
        wdata_next = XLEN'({4{i_data_store[7:0]}});
      end
      2'b01: begin
        be_next    = 4'b0011 << off;
        wdata_next = XLEN'({2{i_data_store[15:0]}});
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = i_data_store;
      end
    endcase
    if (!is_store) wdata_next = '0;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rbyte[gi] = i_dmem_rdata[8*gi +: 8];
  end

  always_comb begin
    lbyte = rbyte[off_reg];
    lhalf = off_reg[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (func3_reg)
      3'b000:  load_data = {{(XLEN-8){lbyte[7]}}, lbyte};
      3'b001:  load_data = {{(XLEN-16){lhalf[15]}}, lhalf};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, lbyte};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, lhalf};
      default: load_data = i_dmem_rdata;
    endcase
  end

  // Memory port is driven straight from the state register so reset drops it at once.
  assign o_dmem_req   = (state_reg == S_WAIT);
  assign o_stall      = o_dmem_req;
  assign o_dmem_we    = o_dmem_req & we_reg;
  assign o_dmem_addr  = o_dmem_req ? addr_reg  : '0;
  assign o_dmem_wdata = o_dmem_req ? wdata_reg : '0;
  assign o_dmem_be    = o_dmem_req ? be_reg    : 4'b0000;

  assign o_fwd_rd   = (o_vld && o_wr) ? o_rd : 5'd0;
  assign o_fwd_data = o_wb_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      pc_reg    <= '0;
      be_reg    <= 4'b0000;
      func3_reg <= 3'b000;
      off_reg   <= 2'b00;
      rd_reg    <= 5'd0;
      o_vld     <= 1'b0;
      o_wr      <= 1'b0;
      o_rd      <= 5'd0;
      o_wb_data <= '0;
      o_pc      <= '0;
      o_trap    <= 1'b0;
      o_trap_pc <= '0;
    end else begin
      o_vld  <= 1'b0;
      o_wr   <= 1'b0;
      o_trap <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (i_vld) begin
            if (is_load || is_store) begin
              if (!f3_ok || misaligned) begin
                o_trap    <= 1'b1;
                o_trap_pc <= i_pc;
              end else begin
                state_reg <= S_WAIT;
                we_reg    <= is_store;
                addr_reg  <= {i_result[XLEN-1:2], 2'b00};
                wdata_reg <= wdata_next;
                be_reg    <= be_next;
                pc_reg    <= i_pc;
                func3_reg <= i_func3;
                off_reg   <= off;
                rd_reg    <= i_rd;
              end
            end else begin
              o_vld     <= 1'b1;
              o_wr      <= (i_opcode != OP_BRANCH) && (i_rd != 5'd0);
              o_rd      <= i_rd;
              o_wb_data <= i_result;
              o_pc      <= i_pc;
            end
          end
        end
        S_WAIT: begin
          if (i_dmem_ack) begin
            state_reg <= S_IDLE;
            o_vld     <= 1'b1;
            o_wr      <= !we_reg && (rd_reg != 5'd0);
            o_rd      <= rd_reg;
            o_wb_data <= we_reg ? '0 : load_data;
            o_pc      <= pc_reg;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected writeback/trap records are queued
// at issue time and popped when the stage reports a completion.
module tb_mem_access_stage;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_vld = 1'b0;
  logic [31:0] i_result = '0, i_data_store = '0, i_pc = '0;
  logic [2:0]  i_func3 = '0;
  logic [6:0]  i_opcode = '0;
  logic [4:0]  i_rd = '0;
  logic        i_dmem_ack = 1'b0;
  logic [31:0] i_dmem_rdata = '0;
  logic        o_stall, o_dmem_req, o_dmem_we, o_vld, o_wr, o_trap;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_data, o_pc, o_fwd_data, o_trap_pc;
  logic [3:0]  o_dmem_be;
  logic [4:0]  o_rd, o_fwd_rd;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        vld;
    logic        wr;
    logic        trap;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic        chk_data;
  } exp_t;
  exp_t sb[$];

  mem_access_stage dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_result(i_result),
    .i_data_store(i_data_store), .i_pc(i_pc), .i_func3(i_func3),
    .i_opcode(i_opcode), .i_rd(i_rd), .o_stall(o_stall),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be), .i_dmem_ack(i_dmem_ack),
    .i_dmem_rdata(i_dmem_rdata), .o_vld(o_vld), .o_wr(o_wr), .o_rd(o_rd),
    .o_wb_data(o_wb_data), .o_pc(o_pc), .o_fwd_rd(o_fwd_rd),
    .o_fwd_data(o_fwd_data), .o_trap(o_trap), .o_trap_pc(o_trap_pc)
  );

  always #5 clk = ~clk;

  task automatic push(input logic vld, input logic wr, input logic trap, input logic [4:0] rd,
                      input logic [31:0] data, input logic [31:0] pc, input logic chk_data);
    exp_t e;
    e.vld = vld; e.wr = wr; e.trap = trap; e.rd = rd;
    e.data = data; e.pc = pc; e.chk_data = chk_data;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] sd, input logic [31:0] pc);
    i_vld = 1'b1; i_opcode = opc; i_func3 = f3; i_rd = rd;
    i_result = res; i_data_store = sd; i_pc = pc;
  endtask

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] sd, input logic [31:0] pc);
    drive(opc, f3, rd, res, sd, pc);
    @(posedge clk); #1;
    i_vld = 1'b0;
  endtask

  // Wait (bounded) for a completion and compare it against the scoreboard head.
  task automatic check_out(input string name);
    exp_t e;
    int n = 0;
    while (!(o_vld || o_trap) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!(o_vld || o_trap)) begin
      failures++;
      $display("FAIL %s timeout: o_vld=%b o_trap=%b, required a completion", name, o_vld, o_trap);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected completion: o_vld=%b o_trap=%b, required none", name, o_vld, o_trap);
      return;
    end
    e = sb.pop_front();
    if (o_vld !== e.vld || o_trap !== e.trap) begin
      failures++;
      $display("FAIL %s kind: vld=%b trap=%b, required vld=%b trap=%b", name, o_vld, o_trap, e.vld, e.trap);
    end
    if (e.vld) begin
      checks++;
      if (o_wr !== e.wr || o_rd !== e.rd || o_pc !== e.pc) begin
        failures++;
        $display("FAIL %s wb: wr=%b rd=%0d pc=%h, required wr=%b rd=%0d pc=%h",
                 name, o_wr, o_rd, o_pc, e.wr, e.rd, e.pc);
      end
      checks++;
      if (o_fwd_rd !== (e.wr ? e.rd : 5'd0)) begin
        failures++;
        $display("FAIL %s fwd_rd: got %0d, required %0d", name, o_fwd_rd, e.wr ? e.rd : 5'd0);
      end
      if (e.chk_data) begin
        checks++;
        if (o_wb_data !== e.data || o_fwd_data !== e.data) begin
          failures++;
          $display("FAIL %s data: wb=%h fwd=%h, required %h", name, o_wb_data, o_fwd_data, e.data);
        end
      end
    end
    if (e.trap) begin
      checks++;
      if (o_trap_pc !== e.pc) begin
        failures++;
        $display("FAIL %s trap_pc: got %h, required %h", name, o_trap_pc, e.pc);
      end
    end
    $display("txn %s: vld=%b wr=%b rd=%0d data=%h trap=%b pc=%h",
             name, o_vld, o_wr, o_rd, o_wb_data, o_trap, e.pc);
  endtask

  // Data-memory responder: holds off ack for n_waits WAIT cycles, checking the port each cycle.
  task automatic mem_serve(input string name, input int n_waits, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic exp_we,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    int stall_cnt = 0;
    for (int w = 1; w <= n_waits; w++) begin
      checks++;
      if (o_dmem_req !== 1'b1 || o_dmem_addr !== exp_addr || o_dmem_we !== exp_we ||
          (exp_we && (o_dmem_be !== exp_be || o_dmem_wdata !== exp_wdata))) begin
        failures++;
        $display("FAIL %s port cyc%0d: req=%b we=%b addr=%h be=%b wdata=%h, required req=1 we=%b addr=%h be=%b wdata=%h",
                 name, w, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
                 exp_we, exp_addr, exp_be, exp_wdata);
      end
      if (o_stall) stall_cnt++;
      if (w == n_waits) begin
        i_dmem_ack = 1'b1;
        i_dmem_rdata = rdata;
      end
      @(posedge clk); #1;
    end
    i_dmem_ack = 1'b0;
    i_dmem_rdata = '0;
    checks++;
    if (stall_cnt != n_waits || o_stall !== 1'b0) begin
      failures++;
      $display("FAIL %s stall: cycles=%0d now=%b, required cycles=%0d now=0", name, stall_cnt, o_stall, n_waits);
    end
    checks++;
    if (o_dmem_req !== 1'b0 || o_dmem_be !== 4'b0000 || o_dmem_addr !== 32'h0) begin
      failures++;
      $display("FAIL %s port idle: req=%b be=%b addr=%h, required all 0", name, o_dmem_req, o_dmem_be, o_dmem_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_vld !== 1'b0 || o_wr !== 1'b0 || o_trap !== 1'b0 || o_stall !== 1'b0 ||
        o_dmem_req !== 1'b0 || o_wb_data !== 32'h0 || o_fwd_rd !== 5'd0 || o_trap_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset: vld=%b wr=%b trap=%b stall=%b req=%b wb=%h fwd_rd=%0d, required all 0",
               o_vld, o_wr, o_trap, o_stall, o_dmem_req, o_wb_data, o_fwd_rd);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    push(1, 1, 0, 5'd5, 32'h1234, 32'h10, 1);
    issue(OP_ALU, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h10);
    check_out("add");
    @(posedge clk); #1;
    checks++;
    if (o_vld !== 1'b0 || o_fwd_rd !== 5'd0) begin
      failures++;
      $display("FAIL add pulse: vld=%b fwd_rd=%0d, required 0 0", o_vld, o_fwd_rd);
    end
    push(1, 0, 0, 5'd7, 32'h0000_0abc, 32'h14, 1);
    issue(OP_BRANCH, 3'b000, 5'd7, 32'h0000_0abc, 32'h0, 32'h14);
    check_out("branch");
    push(1, 0, 0, 5'd0, 32'h5555_aaaa, 32'h18, 1);
    issue(OP_ALU, 3'b000, 5'd0, 32'h5555_aaaa, 32'h0, 32'h18);
    check_out("alu_rd0");
  endtask

  task automatic test_load();
    push(1, 1, 0, 5'd9, 32'hFFFF_FF80, 32'h20, 1);
    issue(OP_LOAD, 3'b000, 5'd9, 32'h103, 32'h0, 32'h20);
    mem_serve("lb", 3, 32'h80FF_FF00, 32'h100, 1'b0, 4'b0000, 32'h0);
    check_out("lb");
    push(1, 1, 0, 5'd4, 32'h0000_8001, 32'h24, 1);
    issue(OP_LOAD, 3'b101, 5'd4, 32'h2, 32'h0, 32'h24);
    mem_serve("lhu", 1, 32'h8001_0000, 32'h0, 1'b0, 4'b0000, 32'h0);
    check_out("lhu");
    push(1, 0, 0, 5'd0, 32'h0000_8001, 32'h28, 1);
    issue(OP_LOAD, 3'b101, 5'd0, 32'h2, 32'h0, 32'h28);
    mem_serve("lhu_rd0", 2, 32'h8001_0000, 32'h0, 1'b0, 4'b0000, 32'h0);
    check_out("lhu_rd0");
    push(1, 1, 0, 5'd11, 32'hFFFF_8123, 32'h2c, 1);
    issue(OP_LOAD, 3'b001, 5'd11, 32'h0, 32'h0, 32'h2c);
    mem_serve("lh", 1, 32'h0000_8123, 32'h0, 1'b0, 4'b0000, 32'h0);
    check_out("lh");
    push(1, 1, 0, 5'd12, 32'h0000_00F2, 32'h30, 1);
    issue(OP_LOAD, 3'b100, 5'd12, 32'h1, 32'h0, 32'h30);
    mem_serve("lbu", 2, 32'h0000_F200, 32'h0, 1'b0, 4'b0000, 32'h0);
    check_out("lbu");
    push(1, 1, 0, 5'd13, 32'hDEAD_BEEF, 32'h34, 1);
    issue(OP_LOAD, 3'b010, 5'd13, 32'h204, 32'h0, 32'h34);
    mem_serve("lw", 2, 32'hDEAD_BEEF, 32'h204, 1'b0, 4'b0000, 32'h0);
    check_out("lw");
  endtask

  task automatic test_store();
    push(1, 0, 0, 5'd0, 32'h0, 32'h50, 0);
    issue(OP_STORE, 3'b001, 5'd0, 32'h102, 32'hABCD_5678, 32'h50);
    mem_serve("sh", 2, 32'h0, 32'h100, 1'b1, 4'b1100, 32'h5678_5678);
    check_out("sh");
    push(1, 0, 0, 5'd0, 32'h0, 32'h54, 0);
    issue(OP_STORE, 3'b000, 5'd0, 32'h101, 32'h1234_56AB, 32'h54);
    mem_serve("sb", 1, 32'h0, 32'h100, 1'b1, 4'b0010, 32'hABAB_ABAB);
    check_out("sb");
    push(1, 0, 0, 5'd0, 32'h0, 32'h58, 0);
    issue(OP_STORE, 3'b010, 5'd0, 32'h300, 32'hCAFE_F00D, 32'h58);
    mem_serve("sw", 3, 32'h0, 32'h300, 1'b1, 4'b1111, 32'hCAFE_F00D);
    check_out("sw");
  endtask

  task automatic test_trap();
    logic [6:0]  opc [4] = '{OP_LOAD, OP_STORE, OP_LOAD, OP_STORE};
    logic [2:0]  f3  [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] adr [4] = '{32'h101, 32'h203, 32'h0, 32'h8};
    for (int k = 0; k < 4; k++) begin
      push(0, 0, 1, 5'd0, 32'h0, 32'h40 + 32'(4*k), 0);
      issue(opc[k], f3[k], 5'd3, adr[k], 32'h1111_2222, 32'h40 + 32'(4*k));
      checks++;
      if (o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin
        failures++;
        $display("FAIL trap%0d req: req=%b stall=%b, required 0 0", k, o_dmem_req, o_stall);
      end
      check_out($sformatf("trap%0d", k));
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      push(1, 1, 0, 5'(k + 1), 32'hA000_0000 + 32'(k), 32'h80 + 32'(4*k), 1);
      drive(OP_ALU, 3'b000, 5'(k + 1), 32'hA000_0000 + 32'(k), 32'h0, 32'h80 + 32'(4*k));
      @(posedge clk); #1;
      check_out($sformatf("b2b%0d", k));
    end
    i_vld = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    issue(OP_LOAD, 3'b010, 5'd6, 32'h80, 32'h0, 32'h60);
    checks++;
    if (o_dmem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid pre: req=%b, required 1", o_dmem_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid drop: req=%b stall=%b, required 0 0", o_dmem_req, o_stall);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    i_dmem_ack = 1'b1;
    i_dmem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    i_dmem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (o_vld || o_trap || o_stall) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_mid late_ack: activity cycles=%0d, required 0", seen);
    end
    push(1, 1, 0, 5'd2, 32'h0000_0777, 32'h64, 1);
    issue(OP_ALU, 3'b000, 5'd2, 32'h0000_0777, 32'h0, 32'h64);
    check_out("post_rst");
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard leftover: %0d entries, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_trap();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
